// File: rtl/rv32_pkg.sv
// Shared RV32 pipeline types: control bundle, write-back select, opcode constants.
// Also holds the canonical NOP word (addi x0,x0,0) used for pipeline bubbles.
package rv32_pkg;

  typedef enum logic [1:0] {
    WB_MEM = 2'd0,
    WB_ALU = 2'd1,
    WB_PC4 = 2'd2
  } WBSel_t;

  typedef struct packed {
    logic       RegWEn;
    logic       MemRW;
    WBSel_t     WBSel;
    logic [3:0] ALUSel;
    logic       ASel;
    logic       BSel;
    logic       BrUn;
  } ctrl_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [31:0] NOP_WORD    = 32'h0000_0013;
  localparam ctrl_t       CTRL_BUBBLE = '0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detect between the load in EX and the instruction in ID.
// Zero latency; pure logic, no backpressure of its own.
module load_use_detect
  import rv32_pkg::*;
(
  input  logic [6:0] opcode_id,
  input  logic [4:0] rs1_id,
  input  logic [4:0] rs2_id,
  input  logic [4:0] rd_ex,
  input  logic       valid_ex,
  input  logic       reg_wen_ex,
  input  WBSel_t     wb_sel_ex,
  output logic       hazard
);

  logic reads_rs1;
  logic reads_rs2;
  logic load_in_ex;

  always_comb begin
    reads_rs1 = !(opcode_id inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
    reads_rs2 = opcode_id inside {OPC_OP, OPC_STORE, OPC_BRANCH};
    // Only a real load with a non-x0 destination can produce data too late to forward.
    load_in_ex = valid_ex && reg_wen_ex && (wb_sel_ex == WB_MEM) && (rd_ex != 5'd0);
    hazard = load_in_ex &&
             ((reads_rs1 && (rs1_id == rd_ex)) || (reads_rs2 && (rs2_id == rd_ex)));
  end

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use stall and flush bubble insertion; one-cycle latency.
// Stalls IF/ID for one cycle per load-use hazard; flush wins. Optional HAZARD_STATS_EN counters.
module id_ex_pipe
  import rv32_pkg::*;
#(
  parameter logic [31:0] NOP_INST = NOP_WORD,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      inst_ID,
  input  logic [31:0]      pc_ID,
  input  logic [31:0]      rs1_data_ID,
  input  logic [31:0]      rs2_data_ID,
  input  logic [31:0]      imm_ID,
  input  ctrl_t            ctrl_ID,
  input  logic             valid_ID,
  input  logic             flush_EX,
  output logic             stall_IF,
  output logic             stall_ID,
  output logic [31:0]      inst_EX,
  output logic [31:0]      pc_EX,
  output logic [31:0]      rs1_data_EX,
  output logic [31:0]      rs2_data_EX,
  output logic [31:0]      imm_EX,
  output ctrl_t            ctrl_EX,
  output logic             valid_EX
`ifdef HAZARD_STATS_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  logic hazard;
  logic stall;
  logic capture;

  load_use_detect u_detect (
    .opcode_id  (inst_ID[6:0]),
    .rs1_id     (inst_ID[19:15]),
    .rs2_id     (inst_ID[24:20]),
    .rd_ex      (inst_EX[11:7]),
    .valid_ex   (valid_EX),
    .reg_wen_ex (ctrl_EX.RegWEn),
    .wb_sel_ex  (ctrl_EX.WBSel),
    .hazard     (hazard)
  );

  // A flushed ID instruction is discarded anyway, so holding IF/ID for it is pointless.
  assign stall    = hazard && !flush_EX;
  assign stall_IF = stall;
  assign stall_ID = stall;
  assign capture  = valid_ID && !hazard && !flush_EX;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_EX     <= NOP_INST;
      pc_EX       <= '0;
      rs1_data_EX <= '0;
      rs2_data_EX <= '0;
      imm_EX      <= '0;
      ctrl_EX     <= CTRL_BUBBLE;
      valid_EX    <= 1'b0;
    end else if (capture) begin
      inst_EX     <= inst_ID;
      pc_EX       <= pc_ID;
      rs1_data_EX <= rs1_data_ID;
      rs2_data_EX <= rs2_data_ID;
      imm_EX      <= imm_ID;
      ctrl_EX     <= ctrl_ID;
      valid_EX    <= 1'b1;
    end else begin
      inst_EX     <= NOP_INST;
      pc_EX       <= '0;
      rs1_data_EX <= '0;
      rs2_data_EX <= '0;
      imm_EX      <= '0;
      ctrl_EX     <= CTRL_BUBBLE;
      valid_EX    <= 1'b0;
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall)    stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_EX) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_pipe.sv
// Bench for id_ex_pipe: directed hazard scenarios plus randomized traffic vs. a reference model.
// Counter checks are active when HAZARD_STATS_EN is defined.
module tb_id_ex_pipe;
  import rv32_pkg::*;

  localparam int CNT_W = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] LW_X5  = 32'h0000_A283;  // lw  x5,0(x1)
  localparam logic [31:0] ADD_X6 = 32'h0022_8333;  // add x6,x5,x2
  localparam logic [31:0] LUI_X5 = 32'h1234_52B7;  // lui x5,0x12345
  localparam logic [31:0] LW_X0  = 32'h0000_A003;  // lw  x0,0(x1)
  localparam logic [31:0] ADD_00 = 32'h0000_0333;  // add x6,x0,x0

  logic clk = 1'b0;
  logic rst_n;
  logic [31:0] inst_ID, pc_ID, rs1_data_ID, rs2_data_ID, imm_ID;
  ctrl_t ctrl_ID;
  logic valid_ID, flush_EX;
  logic stall_IF, stall_ID;
  logic [31:0] inst_EX, pc_EX, rs1_data_EX, rs2_data_EX, imm_EX;
  ctrl_t ctrl_EX;
  logic valid_EX;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: architectural contents of the EX stage and counters.
  logic [31:0] m_inst, m_pc, m_rs1, m_rs2, m_imm;
  ctrl_t m_ctrl;
  logic m_valid;
  int m_scnt, m_fcnt;

  always #5 clk = ~clk;

  id_ex_pipe #(.NOP_INST(NOP), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .inst_ID(inst_ID), .pc_ID(pc_ID), .rs1_data_ID(rs1_data_ID),
    .rs2_data_ID(rs2_data_ID), .imm_ID(imm_ID), .ctrl_ID(ctrl_ID),
    .valid_ID(valid_ID), .flush_EX(flush_EX),
    .stall_IF(stall_IF), .stall_ID(stall_ID),
    .inst_EX(inst_EX), .pc_EX(pc_EX), .rs1_data_EX(rs1_data_EX),
    .rs2_data_EX(rs2_data_EX), .imm_EX(imm_EX), .ctrl_EX(ctrl_EX),
    .valid_EX(valid_EX)
`ifdef HAZARD_STATS_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

`ifndef HAZARD_STATS_EN
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

  function automatic ctrl_t load_ctrl();
    ctrl_t c;
    c = '0;
    c.RegWEn = 1'b1;
    c.WBSel  = WB_MEM;
    return c;
  endfunction

  function automatic ctrl_t alu_ctrl();
    ctrl_t c;
    c = '0;
    c.RegWEn = 1'b1;
    c.WBSel  = WB_ALU;
    return c;
  endfunction

  // Which source registers an instruction reads, stated per instruction class.
  function automatic bit uses_rs1(logic [31:0] i);
    logic [6:0] op;
    op = i[6:0];
    return !(op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111);
  endfunction

  function automatic bit uses_rs2(logic [31:0] i);
    logic [6:0] op;
    op = i[6:0];
    return op == 7'b0110011 || op == 7'b0100011 || op == 7'b1100011;
  endfunction

  function automatic bit model_hazard();
    logic [4:0] rd;
    rd = m_inst[11:7];
    if (!m_valid || !m_ctrl.RegWEn || m_ctrl.WBSel != WB_MEM || rd == 5'd0) return 0;
    return (uses_rs1(inst_ID) && inst_ID[19:15] == rd) ||
           (uses_rs2(inst_ID) && inst_ID[24:20] == rd);
  endfunction

  task automatic model_reset();
    m_inst = NOP; m_pc = 0; m_rs1 = 0; m_rs2 = 0; m_imm = 0;
    m_ctrl = '0; m_valid = 0; m_scnt = 0; m_fcnt = 0;
  endtask

  task automatic set_id(logic [31:0] inst, ctrl_t c, logic [31:0] pc);
    inst_ID = inst; ctrl_ID = c; pc_ID = pc; valid_ID = 1'b1; flush_EX = 1'b0;
    rs1_data_ID = $urandom; rs2_data_ID = $urandom; imm_ID = $urandom;
  endtask

  // One clock: check stall before the edge, advance the model, check EX after the edge.
  task automatic step();
    bit hz, es;
    #1;
    hz = model_hazard();
    es = hz && !flush_EX;
    n_cmp++;
    if (stall_IF !== es || stall_ID !== es) begin
      n_bad++;
      $display("FAIL stall: stall_IF=%b stall_ID=%b expected %b (inst_ID=%h)", stall_IF, stall_ID, es, inst_ID);
    end
    @(posedge clk);
    if (es) m_scnt = (m_scnt + 1) % (1 << CNT_W);
    if (flush_EX) m_fcnt = (m_fcnt + 1) % (1 << CNT_W);
    if (valid_ID && !hz && !flush_EX) begin
      m_inst = inst_ID; m_pc = pc_ID; m_rs1 = rs1_data_ID; m_rs2 = rs2_data_ID;
      m_imm = imm_ID; m_ctrl = ctrl_ID; m_valid = 1'b1;
    end else begin
      m_inst = NOP; m_pc = 0; m_rs1 = 0; m_rs2 = 0; m_imm = 0; m_ctrl = '0; m_valid = 0;
    end
    #1;
    n_cmp++;
    if (inst_EX !== m_inst || pc_EX !== m_pc || rs1_data_EX !== m_rs1 || rs2_data_EX !== m_rs2 ||
        imm_EX !== m_imm || ctrl_EX !== m_ctrl || valid_EX !== m_valid) begin
      n_bad++;
      $display("FAIL ex_regs: got inst=%h pc=%h r1=%h r2=%h imm=%h ctrl=%h v=%b expected inst=%h pc=%h r1=%h r2=%h imm=%h ctrl=%h v=%b",
               inst_EX, pc_EX, rs1_data_EX, rs2_data_EX, imm_EX, ctrl_EX, valid_EX,
               m_inst, m_pc, m_rs1, m_rs2, m_imm, m_ctrl, m_valid);
    end
`ifdef HAZARD_STATS_EN
    n_cmp++;
    if (int'(stall_cnt) !== m_scnt || int'(flush_cnt) !== m_fcnt) begin
      n_bad++;
      $display("FAIL counters: stall_cnt=%0d flush_cnt=%0d expected %0d/%0d", stall_cnt, flush_cnt, m_scnt, m_fcnt);
    end
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_id(32'h0, '0, 32'h0);
    valid_ID = 1'b0;
    model_reset();
    #12;
    n_cmp++;
    if (inst_EX !== NOP || valid_EX !== 1'b0 || ctrl_EX !== ctrl_t'('0) || pc_EX !== 32'h0 ||
        rs1_data_EX !== 32'h0 || rs2_data_EX !== 32'h0 || imm_EX !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_ex: inst=%h v=%b ctrl=%h pc=%h expected bubble", inst_EX, valid_EX, ctrl_EX, pc_EX);
    end
    n_cmp++;
    if (stall_IF !== 1'b0 || stall_ID !== 1'b0 || stall_cnt !== '0 || flush_cnt !== '0) begin
      n_bad++;
      $display("FAIL reset_stall: stall=%b%b cnt=%0d/%0d expected 0", stall_IF, stall_ID, stall_cnt, flush_cnt);
    end
    #5 rst_n = 1'b1;
    #1;
  endtask

  task automatic test_load_use();
    set_id(LW_X5, load_ctrl(), 32'h40);
    step();
    set_id(ADD_X6, alu_ctrl(), 32'h44);
    #1;
    n_cmp++;
    if (stall_IF !== 1'b1 || stall_ID !== 1'b1) begin
      n_bad++;
      $display("FAIL load_use_stall: stall=%b%b expected 11", stall_IF, stall_ID);
    end
    step();
    n_cmp++;
    if (inst_EX !== 32'h0000_0013 || valid_EX !== 1'b0) begin
      n_bad++;
      $display("FAIL load_use_bubble: inst_EX=%h valid=%b expected 00000013/0", inst_EX, valid_EX);
    end
    step();
    n_cmp++;
    if (inst_EX !== ADD_X6 || valid_EX !== 1'b1 || stall_ID !== 1'b0) begin
      n_bad++;
      $display("FAIL load_use_release: inst_EX=%h valid=%b stall=%b expected %h/1/0", inst_EX, valid_EX, stall_ID, ADD_X6);
    end
  endtask

  task automatic test_lui_no_stall();
    set_id(LW_X5, load_ctrl(), 32'h80);
    step();
    set_id(LUI_X5, alu_ctrl(), 32'h84);
    step();
    n_cmp++;
    if (inst_EX !== LUI_X5 || pc_EX !== 32'h84) begin
      n_bad++;
      $display("FAIL lui_capture: inst_EX=%h pc=%h expected %h/00000084", inst_EX, pc_EX, LUI_X5);
    end
  endtask

  task automatic test_x0_no_stall();
    set_id(LW_X0, load_ctrl(), 32'hC0);
    step();
    set_id(ADD_00, alu_ctrl(), 32'hC4);
    step();
    n_cmp++;
    if (inst_EX !== ADD_00 || valid_EX !== 1'b1) begin
      n_bad++;
      $display("FAIL x0_capture: inst_EX=%h valid=%b expected %h/1", inst_EX, valid_EX, ADD_00);
    end
  endtask

  task automatic test_flush_priority();
    logic [CNT_W-1:0] s0, f0;
    set_id(LW_X5, load_ctrl(), 32'h100);
    step();
    set_id(ADD_X6, alu_ctrl(), 32'h104);
    flush_EX = 1'b1;
    s0 = stall_cnt; f0 = flush_cnt;
    step();
    flush_EX = 1'b0;
    n_cmp++;
    if (inst_EX !== NOP || valid_EX !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_bubble: inst_EX=%h valid=%b expected %h/0", inst_EX, valid_EX, NOP);
    end
`ifdef HAZARD_STATS_EN
    n_cmp++;
    if (flush_cnt !== f0 + CNT_W'(1) || stall_cnt !== s0) begin
      n_bad++;
      $display("FAIL flush_counts: flush_cnt=%0d stall_cnt=%0d expected %0d/%0d", flush_cnt, stall_cnt, f0 + CNT_W'(1), s0);
    end
`endif
  endtask

  task automatic test_reset_mid_stall();
    set_id(LW_X5, load_ctrl(), 32'h200);
    step();
    set_id(ADD_X6, alu_ctrl(), 32'h204);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    n_cmp++;
    if (inst_EX !== NOP || valid_EX !== 1'b0 || pc_EX !== 32'h0 || stall_ID !== 1'b0 ||
        stall_IF !== 1'b0 || stall_cnt !== '0 || flush_cnt !== '0) begin
      n_bad++;
      $display("FAIL reset_mid_stall: inst=%h v=%b pc=%h stall=%b%b cnt=%0d/%0d expected bubble/0",
               inst_EX, valid_EX, pc_EX, stall_IF, stall_ID, stall_cnt, flush_cnt);
    end
    rst_n = 1'b1;
    set_id(ADD_X6, alu_ctrl(), 32'h0000_0100);
    step();
    n_cmp++;
    if (pc_EX !== 32'h0000_0100 || valid_EX !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_resume: pc_EX=%h valid=%b expected 00000100/1", pc_EX, valid_EX);
    end
  endtask

  task automatic test_counter_wrap();
    rst_n = 1'b0;
    #1;
    model_reset();
    rst_n = 1'b1;
    for (int k = 0; k < 17; k++) begin
      set_id(LW_X5, load_ctrl(), 32'h300 + 32'(k * 8));
      step();
      set_id(ADD_X6, alu_ctrl(), 32'h304 + 32'(k * 8));
      step();
    end
`ifdef HAZARD_STATS_EN
    n_cmp++;
    if (stall_cnt !== 4'd1) begin
      n_bad++;
      $display("FAIL stall_wrap: stall_cnt=%0d expected 1", stall_cnt);
    end
`endif
  endtask

  task automatic test_random();
    logic [6:0] opcs [9];
    ctrl_t c;
    logic [31:0] w;
    opcs = '{OPC_LOAD, OPC_OP, OPC_OPIMM, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR};
    for (int k = 0; k < 400; k++) begin
      w = $urandom;
      w[6:0]   = opcs[$urandom_range(0, 8)];
      w[11:7]  = 5'($urandom_range(0, 3));
      w[19:15] = 5'($urandom_range(0, 3));
      w[24:20] = 5'($urandom_range(0, 3));
      c = ctrl_t'(10'($urandom));
      c.WBSel = WBSel_t'(2'($urandom_range(0, 2)));
      if (w[6:0] == OPC_LOAD && $urandom_range(0, 3) != 0) c = load_ctrl();
      set_id(w, c, $urandom);
      valid_ID = ($urandom_range(0, 7) != 0);
      flush_EX = ($urandom_range(0, 7) == 0);
      step();
    end
    flush_EX = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_lui_no_stall();
    test_x0_no_stall();
    test_flush_priority();
    test_reset_mid_stall();
    test_counter_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe.md
ID_EX_PIPE -- requirements
Module: id_ex_pipe

Interface
REQ-001 SHALL have parameter NOP_INST, default 32'h0000_0013, the instruction word inserted for a bubble (addi x0,x0,0).
REQ-002 SHALL have parameter CNT_W, default 32, the width of the statistics counters.
REQ-003 SHALL have port clk  input  1  the single pipeline clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have ports inst_ID, pc_ID, rs1_data_ID, rs2_data_ID, imm_ID  input  32 each  decode-stage instruction, PC, register-file read data and immediate.
REQ-006 SHALL have port ctrl_ID  input  ctrl_t  decoded control bundle (RegWEn, MemRW, WBSel, ALUSel, ASel, BSel, BrUn).
REQ-007 SHALL have port valid_ID  input  1  decode stage holds a real instruction.
REQ-008 SHALL have port flush_EX  input  1  branch or jump resolved taken in EX this cycle.
REQ-009 SHALL have ports stall_IF, stall_ID  output  1 each  hold the PC and IF/ID registers.
REQ-010 SHALL have ports inst_EX, pc_EX, rs1_data_EX, rs2_data_EX, imm_EX  output  32 each; ctrl_EX  output  ctrl_t; valid_EX  output  1  registered EX-stage copies.
REQ-011 SHALL have ports stall_cnt, flush_cnt  output  CNT_W each, present only when HAZARD_STATS_EN is defined.

Function
REQ-012 SHALL register all ID inputs into the EX outputs with one-cycle latency when neither a load-use hazard nor flush_EX is active.
REQ-013 SHALL detect load-use when valid_EX, ctrl_EX.RegWEn, ctrl_EX.WBSel==WB_MEM, rd_EX (inst_EX[11:7])!=0 and rd_EX equals a source register that inst_ID actually reads.
REQ-014 SHALL treat rs1 (inst_ID[19:15]) as read for every opcode except LUI, AUIPC and JAL, and rs2 (inst_ID[24:20]) as read only for R-type, STORE and BRANCH.
REQ-015 SHALL drive stall_IF=stall_ID=1 combinationally in a cycle with a load-use hazard and flush_EX=0, and on that edge load a bubble into EX.
REQ-016 SHALL define a bubble as inst_EX=NOP_INST, valid_EX=0, ctrl_EX.RegWEn=0, ctrl_EX.MemRW=0 (read), with pc/data/imm fields zero.
REQ-017 SHALL load a bubble on the edge when flush_EX=1 and force stall_IF=stall_ID=0 in that cycle (flush overrides load-use).
REQ-018 SHALL load a bubble when valid_ID=0, without asserting stall.
REQ-019 SHALL stall for exactly one cycle per load-use hazard: the inserted bubble has valid_EX=0, so detection cannot fire on it.
REQ-020 SHALL leave rd=x0 destinations and non-load producers (WB_ALU, WB_PC4) unstalled; those are resolved by forwarding.

Reset
REQ-021 SHALL, while rst_n=0, asynchronously force the EX outputs to the bubble of REQ-016, stall outputs to 0 and counters to 0.
REQ-022 SHALL resume normal capture on the first rising clk edge after rst_n deasserts; a hazard pending at reset assertion is discarded.

Configuration
REQ-023 SHALL, with HAZARD_STATS_EN defined, increment stall_cnt on every edge where stall_ID=1 and flush_cnt on every edge where flush_EX=1, each wrapping modulo 2^CNT_W.
REQ-024 SHALL, without HAZARD_STATS_EN, omit stall_cnt, flush_cnt and their registers entirely, with identical pipeline behaviour.

Structure
REQ-025 SHALL take ctrl_t, WBSel_t (WB_MEM/WB_ALU/WB_PC4), opcode constants and NOP_INST's value from rv32_pkg.
REQ-026 SHALL implement hazard detection (REQ-013/014) in one combinational sub-module load_use_detect; all registers stay in id_ex_pipe.

Verification
REQ-027 SHALL test: lw x5,0(x1) in EX, add x6,x5,x2 in ID -> stall_IF=stall_ID=1 one cycle, next EX inst=32'h00000013, valid_EX=0; add reaches EX the following cycle.
REQ-028 SHALL test: lw x5 in EX, lui x5,0x12345 in ID -> no stall; lui captured next edge.
REQ-029 SHALL test: lw x0,0(x1) in EX, add x6,x0,x0 in ID -> no stall.
REQ-030 SHALL test: load-use hazard and flush_EX=1 together -> stall=0, bubble loaded, flush_cnt increments by 1, stall_cnt unchanged.
REQ-031 SHALL test: rst_n pulled low mid-stall -> outputs immediately bubble, stall=0, counters 0; after release pc_ID=32'h0000_0100 appears on pc_EX one edge later.
REQ-032 SHALL test with HAZARD_STATS_EN and CNT_W=4: 17 consecutive load-use hazards -> stall_cnt=1 (wrapped).
